// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between the instruction-fetch
// requester and the load/store requester. Accesses of 1/2/4 bytes are
// serialised into little-endian byte beats; load data is assembled,
// optionally sign-extended and returned with a one-cycle done pulse.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iIC_en,
    input  logic [ADDR_W-1:0] iIC_addr,
    output logic              oIC_done,
    output logic [DATA_W-1:0] oIC_dt,
    input  logic              iDC_en,
    input  logic              iDC_ls,
    input  logic [2:0]        iDC_len,
    input  logic              iDC_sext,
    input  logic [3:0]        iDC_nick,
    input  logic [ADDR_W-1:0] iDC_addr,
    input  logic [DATA_W-1:0] iDC_dt,
    output logic              oDC_ready,
    output logic              oDC_done,
    output logic [3:0]        oDC_nick,
    output logic [DATA_W-1:0] oDC_dt,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        IDLE,
        IC_RD,
        DC_RD,
        DC_WR
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        cur_len;
    logic              cur_sext;
    logic [3:0]        cur_nick;
    logic              last_dc;
    logic              alive;
    logic              mem_wr_q;
    logic [DATA_W-1:0] wr_sh;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] rd_asm;
    logic [DATA_W-1:0] rd_ext;

    // one-deep pending load/store register
    logic              pend_v;
    logic              p_ls;
    logic [2:0]        p_len;
    logic              p_sext;
    logic [3:0]        p_nick;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_dt;

    logic ic_req;
    logic grant_dc;
    logic grant_ic;
    logic last_beat;

    assign last_beat = (cnt == (cur_len - 3'd1));
    assign oDC_ready = alive && !pend_v && (state != DC_RD) && (state != DC_WR);
    assign mem_wr    = mem_wr_q && rdy;

    // Round-robin grant; a fetch whose done is currently visible is not
    // re-granted because its requester has not yet dropped iIC_en.
    always_comb begin
        ic_req   = iIC_en && !oIC_done;
        grant_dc = pend_v && (!ic_req || !last_dc);
        grant_ic = ic_req && !grant_dc;
    end

    // Merge the byte arriving this cycle into the read buffer, then extend.
    always_comb begin
        rd_asm = rd_buf;
        rd_asm[{cnt[1:0], 3'b000} +: 8] = mem_din;
        case (cur_len)
            3'd1:    rd_ext = {{(DATA_W-8){cur_sext & rd_asm[7]}}, rd_asm[7:0]};
            3'd2:    rd_ext = {{(DATA_W-16){cur_sext & rd_asm[15]}}, rd_asm[15:0]};
            default: rd_ext = rd_asm;
        endcase
    end

    // Sequencer: pending register, arbitration and byte beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_len  <= '0;
            cur_sext <= 1'b0;
            cur_nick <= '0;
            last_dc  <= 1'b0;
            alive    <= 1'b0;
            mem_wr_q <= 1'b0;
            wr_sh    <= '0;
            rd_buf   <= '0;
            pend_v   <= 1'b0;
            p_ls     <= 1'b0;
            p_len    <= '0;
            p_sext   <= 1'b0;
            p_nick   <= '0;
            p_addr   <= '0;
            p_dt     <= '0;
            oIC_done <= 1'b0;
            oIC_dt   <= '0;
            oDC_done <= 1'b0;
            oDC_nick <= '0;
            oDC_dt   <= '0;
            mem_dout <= '0;
            mem_a    <= '0;
        end else begin
            alive    <= 1'b1;
            oIC_done <= 1'b0;
            oDC_done <= 1'b0;
            if (rdy) begin
                // flush drops a waiting load; a waiting store survives
                if (clr && pend_v && !p_ls)
                    pend_v <= 1'b0;

                case (state)
                    IDLE: begin
                        if (!clr) begin
                            if (grant_dc) begin
                                last_dc  <= 1'b1;
                                pend_v   <= 1'b0;
                                mem_a    <= p_addr;
                                cnt      <= '0;
                                cur_len  <= p_len;
                                cur_sext <= p_sext;
                                cur_nick <= p_nick;
                                rd_buf   <= '0;
                                if (p_ls) begin
                                    state    <= DC_WR;
                                    mem_wr_q <= 1'b1;
                                    mem_dout <= p_dt[7:0];
                                    wr_sh    <= p_dt >> 8;
                                end else begin
                                    state <= DC_RD;
                                end
                            end else if (grant_ic) begin
                                last_dc  <= 1'b0;
                                mem_a    <= iIC_addr;
                                cnt      <= '0;
                                cur_len  <= 3'd4;
                                cur_sext <= 1'b0;
                                rd_buf   <= '0;
                                state    <= IC_RD;
                            end
                        end
                    end
                    IC_RD, DC_RD: begin
                        if (clr) begin
                            state <= IDLE;
                            mem_a <= '0;
                            cnt   <= '0;
                        end else if (last_beat) begin
                            state <= IDLE;
                            mem_a <= '0;
                            cnt   <= '0;
                            if (state == IC_RD) begin
                                oIC_done <= 1'b1;
                                oIC_dt   <= rd_asm;
                            end else begin
                                oDC_done <= 1'b1;
                                oDC_nick <= cur_nick;
                                oDC_dt   <= rd_ext;
                            end
                        end else begin
                            rd_buf <= rd_asm;
                            cnt    <= cnt + 3'd1;
                            mem_a  <= mem_a + A_ONE;
                        end
                    end
                    DC_WR: begin
                        if (last_beat) begin
                            state    <= IDLE;
                            mem_wr_q <= 1'b0;
                            mem_a    <= '0;
                            cnt      <= '0;
                            oDC_done <= 1'b1;
                            oDC_nick <= cur_nick;
                            oDC_dt   <= '0;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            mem_a    <= mem_a + A_ONE;
                            mem_dout <= wr_sh[7:0];
                            wr_sh    <= wr_sh >> 8;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // capture last so a legal request is never lost
                if (iDC_en) begin
                    pend_v <= 1'b1;
                    p_ls   <= iDC_ls;
                    p_len  <= iDC_len;
                    p_sext <= iDC_sext;
                    p_nick <= iDC_nick;
                    p_addr <= iDC_addr;
                    p_dt   <= iDC_dt;
                end
            end
        end
    end

endmodule
